// File: rtl/video_timing_if.sv
// Pixel-enable input and raster timing outputs of the video timing generator.
// The master side is the generator; the slave side supplies the enable and consumes timing.
interface video_timing_if;
   logic       pixel_clken;
   logic [8:0] h_count;
   logic [8:0] v_count;
   logic       hsync_n;
   logic       vsync_n;
   logic       blank;
   logic [5:0] char_col;
   logic [2:0] char_px;
   logic [4:0] char_row;
   logic [2:0] char_scan;
   logic       frame_start;
   logic       blink;

   modport master (
      input  pixel_clken,
      output h_count, v_count, hsync_n, vsync_n, blank,
             char_col, char_px, char_row, char_scan, frame_start, blink
   );

   modport slave (
      output pixel_clken,
      input  h_count, v_count, hsync_n, vsync_n, blank,
             char_col, char_px, char_row, char_scan, frame_start, blink
   );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator for the 40x24 text display: counters, syncs, blanking,
// character-cell coordinates, frame pulse and cursor blink phase.
module video_timing #(
   parameter int H_TOTAL      = 448,
   parameter int H_ACTIVE     = 280,
   parameter int HS_START     = 320,
   parameter int HS_WIDTH     = 32,
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 192,
   parameter int VS_START     = 224,
   parameter int VS_WIDTH     = 3,
   parameter int CHAR_W       = 7,
   parameter int BLINK_FRAMES = 30
) (
   input  logic           sys_clock,
   input  logic           reset_n,
   video_timing_if.master vid
);

   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
   localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
   localparam logic [8:0] HS_BEG   = 9'(HS_START);
   localparam logic [8:0] HS_END   = 9'(HS_START + HS_WIDTH);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
   localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
   localparam logic [8:0] VS_BEG   = 9'(VS_START);
   localparam logic [8:0] VS_END   = 9'(VS_START + VS_WIDTH);
   localparam logic [2:0] PX_LAST  = 3'(CHAR_W - 1);
   localparam logic [5:0] COL_LAST = 6'd39;
   localparam int         FCW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FCW-1:0] F_LAST = FCW'(BLINK_FRAMES - 1);

   logic [8:0]     r_hCount;
   logic [8:0]     r_vCount;
   logic [5:0]     r_charCol;
   logic [2:0]     r_charPx;
   logic           r_hsyncN;
   logic           r_vsyncN;
   logic           r_blank;
   logic           r_frameStart;
   logic           r_blink;
   logic [FCW-1:0] r_frameCnt;

   logic       w_hWrap;
   logic       w_vWrap;
   logic       w_frameWrap;
   logic [8:0] w_hNext;
   logic [8:0] w_vNext;

   assign w_hWrap     = (r_hCount == H_LAST);
   assign w_vWrap     = (r_vCount == V_LAST);
   assign w_frameWrap = w_hWrap && w_vWrap;
   assign w_hNext     = w_hWrap ? 9'd0 : r_hCount + 9'd1;
   assign w_vNext     = w_hWrap ? (w_vWrap ? 9'd0 : r_vCount + 9'd1) : r_vCount;

   // Syncs and blank are decoded from the next counter values so they land on the same edge.
   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_hCount     <= 9'd0;
         r_vCount     <= 9'd0;
         r_charCol    <= 6'd0;
         r_charPx     <= 3'd0;
         r_hsyncN     <= 1'b1;
         r_vsyncN     <= 1'b1;
         r_blank      <= 1'b0;
         r_frameStart <= 1'b0;
         r_blink      <= 1'b0;
         r_frameCnt   <= '0;
      end else begin
         r_frameStart <= 1'b0;
         if (vid.pixel_clken) begin
            r_hCount <= w_hNext;
            r_vCount <= w_vNext;
            if (w_hWrap) begin
               r_charPx  <= 3'd0;
               r_charCol <= 6'd0;
            end else if (w_hNext < H_ACT) begin
               if (r_charPx == PX_LAST) begin
                  r_charPx  <= 3'd0;
                  r_charCol <= r_charCol + 6'd1;
               end else begin
                  r_charPx <= r_charPx + 3'd1;
               end
            end else begin
               r_charPx  <= 3'd0;
               r_charCol <= COL_LAST;
            end
            r_hsyncN <= !((w_hNext >= HS_BEG) && (w_hNext < HS_END));
            r_vsyncN <= !((w_vNext >= VS_BEG) && (w_vNext < VS_END));
            r_blank  <= (w_hNext >= H_ACT) || (w_vNext >= V_ACT);
            if (w_frameWrap) begin
               r_frameStart <= 1'b1;
               if (r_frameCnt == F_LAST) begin
                  r_frameCnt <= '0;
                  r_blink    <= !r_blink;
               end else begin
                  r_frameCnt <= r_frameCnt + FCW'(1);
               end
            end
         end
      end
   end

   assign vid.h_count     = r_hCount;
   assign vid.v_count     = r_vCount;
   assign vid.hsync_n     = r_hsyncN;
   assign vid.vsync_n     = r_vsyncN;
   assign vid.blank       = r_blank;
   assign vid.char_col    = r_charCol;
   assign vid.char_px     = r_charPx;
   assign vid.char_row    = (r_vCount < V_ACT) ? r_vCount[7:3] : 5'd23;
   assign vid.char_scan   = r_vCount[2:0];
   assign vid.frame_start = r_frameStart;
   assign vid.blink       = r_blink;

endmodule
